// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1
   } pc_state_e;

   localparam logic [63:0] RESET_VEC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator: RUN/HALT FSM, trap and redirect steering,
// a one-entry pending redirect for HALT, and cycle/fetch counters.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned         XLEN      = 64,
   parameter logic [XLEN-1:0]     RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
   parameter int unsigned         INC       = 4,
   parameter int unsigned         CNT_W     = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              fetch_ready_i,
   input  logic              redirect_valid_i,
   input  logic [XLEN-1:0]   redirect_target_i,
   input  logic              trap_valid_i,
   input  logic [XLEN-1:0]   trap_vec_i,
   input  logic              halt_i,
   input  logic              resume_i,
   output logic              pc_valid_o,
   output logic [XLEN-1:0]   pc_o,
   output logic [XLEN-1:0]   next_pc_o,
   output logic              misalign_o,
   output logic [1:0]        state_o,
   output logic [CNT_W-1:0]  cycle_o,
   output logic [CNT_W-1:0]  fetch_cnt_o
);

   pc_state_e         state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              pc_valid_q;
   logic              pend_valid_q, pend_valid_d;
   logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
   logic              misalign_q;
   logic [CNT_W-1:0]  cycle_q;
   logic [CNT_W-1:0]  fetch_cnt_q;

   logic              redir_misaligned;
   logic              handshake;
   logic [XLEN-1:0]   trap_pc;

   // Strict priority: trap, then any redirect (a misaligned one still
   // occupies the edge, leaving pc/state untouched), then halt/resume,
   // then sequential advance.
   always_comb begin
      redir_misaligned = redirect_valid_i && (redirect_target_i[1:0] != 2'b00);
      handshake        = pc_valid_q && fetch_ready_i;
      trap_pc          = trap_vec_i & ~XLEN'(3);

      state_d      = state_q;
      pc_d         = pc_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;

      if (trap_valid_i) begin
         pc_d         = trap_pc;
         state_d      = RUN;
         pend_valid_d = 1'b0;
      end else if (redirect_valid_i) begin
         if (!redir_misaligned) begin
            if (state_q == RUN) begin
               pc_d = redirect_target_i;
            end else begin
               pend_valid_d = 1'b1;
               pend_pc_d    = redirect_target_i;
            end
         end
      end else if (state_q == HALT) begin
         if (resume_i) begin
            state_d      = RUN;
            pend_valid_d = 1'b0;
            if (pend_valid_q) begin
               pc_d = pend_pc_q;
            end
         end
      end else begin
         if (halt_i) begin
            state_d = HALT;
         end
         if (handshake) begin
            pc_d = pc_q + XLEN'(INC);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= RUN;
         pc_valid_q   <= 1'b1;
         pc_q         <= RESET_VEC;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
         misalign_q   <= 1'b0;
         cycle_q      <= '0;
         fetch_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_valid_q   <= (state_d == RUN);
         pc_q         <= pc_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
         misalign_q   <= redir_misaligned && !trap_valid_i;
         cycle_q      <= cycle_q + CNT_W'(1);
         if (handshake) begin
            fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
         end
      end
   end

   assign pc_valid_o  = pc_valid_q;
   assign pc_o        = pc_q;
   assign next_pc_o   = pc_d;
   assign misalign_o  = misalign_q;
   assign state_o     = state_q;
   assign cycle_o     = cycle_q;
   assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: a 64-bit default instance and a
// 32-bit instance with narrow counters for wrap behaviour.
module tb_pc_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   // DUT A: default parameters
   logic        a_rst, a_fr, a_rv, a_tv, a_halt, a_res;
   logic [63:0] a_rt, a_tvec;
   logic        a_pv, a_mis;
   logic [63:0] a_pc, a_npc, a_cyc, a_fcnt;
   logic [1:0]  a_st;

   pc_gen u_a (
      .clk_i             (clk),
      .rst_i             (a_rst),
      .fetch_ready_i     (a_fr),
      .redirect_valid_i  (a_rv),
      .redirect_target_i (a_rt),
      .trap_valid_i      (a_tv),
      .trap_vec_i        (a_tvec),
      .halt_i            (a_halt),
      .resume_i          (a_res),
      .pc_valid_o        (a_pv),
      .pc_o              (a_pc),
      .next_pc_o         (a_npc),
      .misalign_o        (a_mis),
      .state_o           (a_st),
      .cycle_o           (a_cyc),
      .fetch_cnt_o       (a_fcnt)
   );

   // DUT B: 32-bit PC near the top of the address space, 3-bit counters
   logic        b_rst, b_fr;
   logic        b_pv, b_mis;
   logic [31:0] b_pc, b_npc;
   logic [1:0]  b_st;
   logic [2:0]  b_cyc, b_fcnt;

   pc_gen #(
      .XLEN      (32),
      .RESET_VEC (32'hFFFF_FFF8),
      .INC       (4),
      .CNT_W     (3)
   ) u_b (
      .clk_i             (clk),
      .rst_i             (b_rst),
      .fetch_ready_i     (b_fr),
      .redirect_valid_i  (1'b0),
      .redirect_target_i (32'h0),
      .trap_valid_i      (1'b0),
      .trap_vec_i        (32'h0),
      .halt_i            (1'b0),
      .resume_i          (1'b0),
      .pc_valid_o        (b_pv),
      .pc_o              (b_pc),
      .next_pc_o         (b_npc),
      .misalign_o        (b_mis),
      .state_o           (b_st),
      .cycle_o           (b_cyc),
      .fetch_cnt_o       (b_fcnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_rst = 1'b1; a_fr = 1'b0; a_rv = 1'b0; a_tv = 1'b0;
      a_halt = 1'b0; a_res = 1'b0; a_rt = '0; a_tvec = '0;
      b_rst = 1'b1; b_fr = 1'b0;

      step();
      a_rst = 1'b0;
      check("rst_pc",    a_pc,   64'h8000_0000);
      check("rst_valid", {63'd0, a_pv}, 64'd1);
      check("rst_state", {62'd0, a_st}, 64'd0);
      check("rst_cycle", a_cyc,  64'd0);
      check("rst_fcnt",  a_fcnt, 64'd0);
      check("rst_mis",   {63'd0, a_mis}, 64'd0);

      // sequential fetch
      a_fr = 1'b1;
      #1 check("npc_seq", a_npc, 64'h8000_0004);
      step(); check("seq_pc1", a_pc, 64'h8000_0004);
      step(); check("seq_pc2", a_pc, 64'h8000_0008);
      step(); check("seq_pc3", a_pc, 64'h8000_000C);
      check("seq_fcnt",  a_fcnt, 64'd3);
      check("seq_cycle", a_cyc,  64'd3);

      // stall
      a_fr = 1'b0;
      step(); check("stall_pc", a_pc, 64'h8000_000C);

      // aligned redirect in RUN without handshake
      a_rv = 1'b1; a_rt = 64'h8000_1000;
      #1 check("npc_redir", a_npc, 64'h8000_1000);
      step(); a_rv = 1'b0;
      check("redir_pc",   a_pc,   64'h8000_1000);
      check("redir_fcnt", a_fcnt, 64'd3);

      // misaligned redirect
      a_rv = 1'b1; a_rt = 64'h8000_1002;
      step(); a_rv = 1'b0;
      check("mis_pc",   a_pc, 64'h8000_1000);
      check("mis_hi",   {63'd0, a_mis}, 64'd1);
      step();
      check("mis_lo",   {63'd0, a_mis}, 64'd0);

      // halt, redirect held pending, resume
      a_halt = 1'b1;
      step(); a_halt = 1'b0;
      check("halt_valid", {63'd0, a_pv}, 64'd0);
      check("halt_state", {62'd0, a_st}, 64'd1);
      a_rv = 1'b1; a_rt = 64'h8000_2000;
      step(); a_rv = 1'b0;
      check("halt_redir_pc", a_pc, 64'h8000_1000);
      a_fr = 1'b1;
      step(); a_fr = 1'b0;
      check("halt_nofetch_pc",   a_pc,   64'h8000_1000);
      check("halt_nofetch_fcnt", a_fcnt, 64'd3);
      a_res = 1'b1;
      #1 check("npc_resume", a_npc, 64'h8000_2000);
      step(); a_res = 1'b0;
      check("resume_pc",    a_pc, 64'h8000_2000);
      check("resume_valid", {63'd0, a_pv}, 64'd1);

      // trap + redirect in HALT with a stale pending target
      a_halt = 1'b1;
      step(); a_halt = 1'b0;
      a_rv = 1'b1; a_rt = 64'h8000_3000;
      step();
      a_tv = 1'b1; a_tvec = 64'h8000_0103; a_rt = 64'h8000_4000;
      step(); a_tv = 1'b0; a_rv = 1'b0;
      check("trap_pc",    a_pc, 64'h8000_0100);
      check("trap_state", {62'd0, a_st}, 64'd0);
      a_halt = 1'b1;
      step(); a_halt = 1'b0;
      a_res = 1'b1;
      step(); a_res = 1'b0;
      check("trap_pend_clr", a_pc, 64'h8000_0100);

      // halt with a simultaneous accepted handshake still advances
      a_fr = 1'b1; a_halt = 1'b1;
      step(); a_fr = 1'b0; a_halt = 1'b0;
      check("halt_adv_pc",    a_pc,   64'h8000_0104);
      check("halt_adv_state", {62'd0, a_st}, 64'd1);
      check("halt_adv_fcnt",  a_fcnt, 64'd4);

      // halt and resume together in HALT: resume wins
      a_halt = 1'b1; a_res = 1'b1;
      step(); a_halt = 1'b0; a_res = 1'b0;
      check("hr_state", {62'd0, a_st}, 64'd0);

      // reset overrides everything at the same edge
      a_rst = 1'b1; a_tv = 1'b1; a_rv = 1'b1; a_fr = 1'b1; a_halt = 1'b1;
      step();
      a_rst = 1'b0; a_tv = 1'b0; a_rv = 1'b0; a_fr = 1'b0; a_halt = 1'b0;
      check("rst2_pc",    a_pc,   64'h8000_0000);
      check("rst2_state", {62'd0, a_st}, 64'd0);
      check("rst2_cycle", a_cyc,  64'd0);
      check("rst2_fcnt",  a_fcnt, 64'd0);

      // 32-bit PC wrap and narrow counter wrap
      b_rst = 1'b0;
      check("b_rst_pc", {32'd0, b_pc}, 64'hFFFF_FFF8);
      b_fr = 1'b1;
      step(); check("b_pc1", {32'd0, b_pc}, 64'hFFFF_FFFC);
      step(); check("b_wrap_pc", {32'd0, b_pc}, 64'h0);
      for (int i = 0; i < 6; i++) step();
      b_fr = 1'b0;
      check("b_pc_end",   {32'd0, b_pc},   64'h18);
      check("b_fcnt_wrap", {61'd0, b_fcnt}, 64'd0);
      check("b_mis",      {63'd0, b_mis}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1);
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 64, PC/address width.
REQ-002 Parameter RESET_VEC, default 64'h8000_0000 truncated to XLEN, PC value after reset.
REQ-003 Parameter INC, default 4, sequential PC increment.
REQ-004 Parameter CNT_W, default 64, width of the cycle and fetch counters.
REQ-005 clk_i  in  1  sole clock; all state updates on posedge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 fetch_ready_i  in  1  fetch stage accepts pc_o this cycle.
REQ-008 redirect_valid_i  in  1  branch/jump redirect request.
REQ-009 redirect_target_i  in  XLEN  redirect target address.
REQ-010 trap_valid_i  in  1  trap/exception redirect request.
REQ-011 trap_vec_i  in  XLEN  trap vector base; bits [1:0] are mode bits, ignored.
REQ-012 halt_i  in  1  request to stop issuing PCs.
REQ-013 resume_i  in  1  request to leave HALT.
REQ-014 pc_valid_o  out  1  pc_o is a valid fetch address.
REQ-015 pc_o  out  XLEN  current PC.
REQ-016 next_pc_o  out  XLEN  value pc_o takes at the next edge, rst_i excluded.
REQ-017 misalign_o  out  1  one-cycle pulse: rejected misaligned redirect.
REQ-018 state_o  out  2  current FSM state encoding.
REQ-019 cycle_o  out  CNT_W  cycles since reset.
REQ-020 fetch_cnt_o  out  CNT_W  completed fetch handshakes since reset.

Function
REQ-021 FSM states RUN and HALT; pc_valid_o SHALL be 1 exactly in RUN.
REQ-022 Per-edge priority SHALL be: rst_i > trap > redirect > halt/resume > sequential advance.
REQ-023 Trap (any state): pc <= {trap_vec_i[XLEN-1:2],2'b00}, state <= RUN, pending redirect cleared.
REQ-024 Redirect in RUN with target[1:0]==0: pc <= target regardless of fetch_ready_i; no sequential advance that cycle.
REQ-025 Redirect with target[1:0]!=0 (either state): pc and pending unchanged; misalign_o =1 the following cycle only.
REQ-026 Aligned redirect in HALT: target stored in a one-entry pending register (newer overwrites older); pc unchanged.
REQ-027 RUN, no trap/redirect, pc_valid_o && fetch_ready_i: pc <= pc + INC, modulo 2^XLEN (wraps to 0).
REQ-028 RUN with fetch_ready_i=0 and no trap/redirect: pc held.
REQ-029 halt_i in RUN: state <= HALT; an accepted handshake in that same cycle still advances pc.
REQ-030 resume_i in HALT: state <= RUN; pc <= pending target if pending valid, else held; pending cleared.
REQ-031 halt_i and resume_i both high in HALT: resume wins; in RUN resume_i is ignored.
REQ-032 fetch_cnt_o SHALL increment on each cycle with pc_valid_o && fetch_ready_i; both counters wrap modulo 2^CNT_W.
REQ-033 cycle_o SHALL increment every non-reset cycle.
REQ-034 next_pc_o SHALL be combinational and equal pc_o's next value per REQ-022..030.

Reset
REQ-035 On rst_i at an edge: pc_o=RESET_VEC, state RUN, pc_valid_o=1 the next cycle, pending cleared, misalign_o=0, both counters 0.
REQ-036 rst_i mid-operation (any state, any pending input) SHALL override all other requests at that edge.

Structure
REQ-037 Package pc_pkg SHALL hold the state enum (RUN=0, HALT=1) and the default RESET_VEC constant.
REQ-038 No sub-module; counters and FSM inline in pc_gen.

Verification
REQ-039 Reset then fetch_ready_i=1 for 3 cycles -> pc_o 0x80000000,0x80000004,0x80000008,0x8000000C; fetch_cnt_o=3.
REQ-040 RUN, redirect 0x80001000 with fetch_ready_i=0 -> pc_o=0x80001000 next cycle; fetch_cnt_o unchanged.
REQ-041 Redirect 0x80001002 -> pc unchanged, misalign_o high exactly one cycle.
REQ-042 halt_i, then redirect 0x80002000 in HALT, then resume_i -> pc_valid_o=0 during HALT, pc_o=0x80002000 with pc_valid_o=1 after resume.
REQ-043 Trap (trap_vec_i=0x80000103) and redirect same cycle in HALT -> pc_o=0x80000100, state RUN, pending cleared.
REQ-044 XLEN=32, pc=0xFFFFFFFC, fetch accepted -> pc_o=0x00000000.
